// File: rtl/mcs4_pkg.sv
// Shared MCS-4 bus types: data nibble, instruction-cycle phases and I/O-RAM opcodes,
// plus default 4002 geometry.
package mcs4;

    localparam int Ram_regs_per_chip  = 4;
    localparam int Ram_chars_per_reg  = 16;
    localparam int Ram_status_per_reg = 4;

    typedef logic [3:0] char_t;

    typedef enum logic [2:0] {
        PH_A1 = 3'd0,
        PH_A2 = 3'd1,
        PH_A3 = 3'd2,
        PH_M1 = 3'd3,
        PH_M2 = 3'd4,
        PH_X1 = 3'd5,
        PH_X2 = 3'd6,
        PH_X3 = 3'd7
    } instr_cyc_t;

    typedef enum logic [3:0] {
        OP_WRM = 4'h0,
        OP_WMP = 4'h1,
        OP_WRR = 4'h2,
        OP_WPM = 4'h3,
        OP_WR0 = 4'h4,
        OP_WR1 = 4'h5,
        OP_WR2 = 4'h6,
        OP_WR3 = 4'h7,
        OP_SBM = 4'h8,
        OP_RDM = 4'h9,
        OP_RDR = 4'hA,
        OP_ADM = 4'hB,
        OP_RD0 = 4'hC,
        OP_RD1 = 4'hD,
        OP_RD2 = 4'hE,
        OP_RD3 = 4'hF
    } ioram_opa_t;

endpackage

// File: rtl/mcs4_phase_gen.sv
// Local 8-phase instruction-cycle counter regenerated from CPU SYNC.
// phase_valid stays low until the first SYNC has been seen.
module mcs4_phase_gen (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sync,
    output logic [2:0] phase,
    output logic       phase_valid
);

    logic [2:0] phase_q, phase_d;
    logic       phase_valid_q, phase_valid_d;

    always_comb begin
        phase_d       = sync ? 3'd0 : phase_q + 3'd1;
        phase_valid_d = phase_valid_q | sync;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q       <= 3'd0;
            phase_valid_q <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            phase_valid_q <= phase_valid_d;
        end
    end

    assign phase       = phase_q;
    assign phase_valid = phase_valid_q;

endmodule

// File: rtl/mcs4_ram_bank.sv
// Bank of NUM_CHIPS 4002-class RAMs sharing one CM-RAM line, decoding SRC and I/O-RAM opcodes.
// Optional power-up clear sweep of all main and status characters: RAM_BANK_CLEAR_EN.
module mcs4_ram_bank
    import mcs4::*;
#(
    parameter int NUM_CHIPS = 4,
    parameter int CHIP_BASE = 0,
    parameter int REGS      = Ram_regs_per_chip,
    parameter int CHARS     = Ram_chars_per_reg,
    parameter int STATUS    = Ram_status_per_reg
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sync,
    input  logic                     cm_ram,
    input  logic [3:0]               dbus_in,
    output logic [3:0]               dbus_out,
    output logic                     dbus_oe,
    output logic [4*NUM_CHIPS-1:0]   io_out,
    output logic                     busy
);

    localparam int MEM_DEPTH = NUM_CHIPS * REGS * CHARS;
    localparam int ST_DEPTH  = NUM_CHIPS * REGS * STATUS;
    localparam int MEM_AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int ST_AW     = (ST_DEPTH > 1) ? $clog2(ST_DEPTH) : 1;

    logic [2:0] phase;
    logic       phase_valid;
    instr_cyc_t cyc;

    mcs4_phase_gen u_phase (
        .clk         (clk),
        .rst_n       (rst_n),
        .sync        (sync),
        .phase       (phase),
        .phase_valid (phase_valid)
    );

    assign cyc = instr_cyc_t'(phase);

    // SYNC normally arrives during X3; anywhere else it aborts the cycle in flight.
    logic restart, act;
    assign restart = sync && (cyc != PH_X3);
    assign act     = phase_valid && !restart;

    logic [1:0] addr_chip_q, addr_chip_d;
    logic [1:0] addr_reg_q, addr_reg_d;
    char_t      addr_char_q, addr_char_d;
    char_t      src_hi_q, src_hi_d;
    logic       src_pending_q, src_pending_d;
    char_t      opa_q, opa_d;
    logic       op_valid_q, op_valid_d;
    logic       dbus_oe_q, dbus_oe_d;
    logic       rd_st_q, rd_st_d;
    char_t      mem_rd_q, st_rd_q;

    char_t mem [MEM_DEPTH];
    char_t stat [ST_DEPTH];

    ioram_opa_t opa;
    int         chip_idx;
    logic       chip_hit, reg_ok, char_ok, stat_ok;
    logic       base_sel, mem_sel, st_sel;
    logic       mem_rd_op, st_rd_op, st_wr_op, rd_hit;
    logic       mem_we, st_we, io_we;
    logic [MEM_AW-1:0] mem_idx;
    logic [ST_AW-1:0]  st_idx;

    assign opa      = ioram_opa_t'(opa_q);
    assign chip_idx = int'(addr_chip_q) - CHIP_BASE;
    assign chip_hit = (chip_idx >= 0) && (chip_idx < NUM_CHIPS);
    assign reg_ok   = int'(addr_reg_q) < REGS;
    assign char_ok  = int'(addr_char_q) < CHARS;
    assign stat_ok  = int'(opa_q[1:0]) < STATUS;

    assign base_sel = op_valid_q && phase_valid && !busy && chip_hit;
    assign mem_sel  = base_sel && reg_ok && char_ok;
    assign st_sel   = base_sel && reg_ok && stat_ok;

    assign mem_idx = MEM_AW'((chip_idx * REGS + int'(addr_reg_q)) * CHARS + int'(addr_char_q));
    assign st_idx  = ST_AW'((chip_idx * REGS + int'(addr_reg_q)) * STATUS + int'(opa_q[1:0]));

    assign mem_rd_op = (opa == OP_RDM) || (opa == OP_SBM) || (opa == OP_ADM);
    assign st_rd_op  = (opa_q[3:2] == 2'b11);
    assign st_wr_op  = (opa_q[3:2] == 2'b01);
    assign rd_hit    = (mem_rd_op && mem_sel) || (st_rd_op && st_sel);

    assign mem_we = act && (cyc == PH_X2) && (opa == OP_WRM) && mem_sel;
    assign st_we  = act && (cyc == PH_X2) && st_wr_op && st_sel;
    // The output port belongs to the chip, so only the chip code has to match.
    assign io_we  = act && (cyc == PH_X2) && (opa == OP_WMP) && base_sel;

    always_comb begin
        addr_chip_d   = addr_chip_q;
        addr_reg_d    = addr_reg_q;
        addr_char_d   = addr_char_q;
        src_hi_d      = src_hi_q;
        src_pending_d = src_pending_q;
        opa_d         = opa_q;
        op_valid_d    = op_valid_q;
        dbus_oe_d     = 1'b0;
        rd_st_d       = rd_st_q;
        if (restart) begin
            src_pending_d = 1'b0;
            op_valid_d    = 1'b0;
        end else if (phase_valid) begin
            case (cyc)
                PH_M2: begin
                    opa_d      = dbus_in;
                    op_valid_d = cm_ram;
                end
                PH_X1: begin
                    dbus_oe_d = rd_hit;
                    rd_st_d   = st_rd_op;
                end
                PH_X2: begin
                    if (cm_ram) begin
                        src_hi_d      = dbus_in;
                        src_pending_d = 1'b1;
                    end
                end
                PH_X3: begin
                    op_valid_d = 1'b0;
                    if (src_pending_q) begin
                        addr_chip_d   = src_hi_q[3:2];
                        addr_reg_d    = src_hi_q[1:0];
                        addr_char_d   = dbus_in;
                        src_pending_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_chip_q   <= 2'd0;
            addr_reg_q    <= 2'd0;
            addr_char_q   <= 4'd0;
            src_hi_q      <= 4'd0;
            src_pending_q <= 1'b0;
            opa_q         <= 4'd0;
            op_valid_q    <= 1'b0;
            dbus_oe_q     <= 1'b0;
            rd_st_q       <= 1'b0;
        end else begin
            addr_chip_q   <= addr_chip_d;
            addr_reg_q    <= addr_reg_d;
            addr_char_q   <= addr_char_d;
            src_hi_q      <= src_hi_d;
            src_pending_q <= src_pending_d;
            opa_q         <= opa_d;
            op_valid_q    <= op_valid_d;
            dbus_oe_q     <= dbus_oe_d;
            rd_st_q       <= rd_st_d;
        end
    end

    assign dbus_out = dbus_oe_q ? (rd_st_q ? st_rd_q : mem_rd_q) : 4'h0;
    assign dbus_oe  = dbus_oe_q;

`ifdef RAM_BANK_CLEAR_EN
    // Sweep length covers whichever array is deeper so status always finishes too.
    localparam int CLR_LEN = (MEM_DEPTH > ST_DEPTH) ? MEM_DEPTH : ST_DEPTH;
    localparam int CLR_W   = (CLR_LEN > 1) ? $clog2(CLR_LEN) : 1;

    typedef enum logic {CS_IDLE, CS_CLEAR} clr_state_t;

    clr_state_t        clr_state_q;
    logic              clr_armed_q;
    logic [CLR_W-1:0]  clr_cnt_q;
    logic              busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_state_q <= CS_IDLE;
            clr_armed_q <= 1'b1;
            clr_cnt_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (clr_state_q)
                CS_IDLE: begin
                    if (clr_armed_q) begin
                        clr_state_q <= CS_CLEAR;
                        clr_armed_q <= 1'b0;
                        clr_cnt_q   <= '0;
                        busy_q      <= 1'b1;
                    end
                end
                CS_CLEAR: begin
                    if (clr_cnt_q == CLR_W'(CLR_LEN - 1)) begin
                        clr_state_q <= CS_IDLE;
                        busy_q      <= 1'b0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                    end
                end
                default: clr_state_q <= CS_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
`else
    assign busy = 1'b0;
`endif

    logic              mem_wr_en, st_wr_en;
    logic [MEM_AW-1:0] mem_wr_addr;
    logic [ST_AW-1:0]  st_wr_addr;
    char_t             mem_wr_data, st_wr_data;

    always_comb begin
        mem_wr_en   = mem_we;
        mem_wr_addr = mem_idx;
        mem_wr_data = dbus_in;
        st_wr_en    = st_we;
        st_wr_addr  = st_idx;
        st_wr_data  = dbus_in;
`ifdef RAM_BANK_CLEAR_EN
        if (clr_state_q == CS_CLEAR) begin
            mem_wr_en   = int'(clr_cnt_q) < MEM_DEPTH;
            mem_wr_addr = MEM_AW'(clr_cnt_q);
            mem_wr_data = 4'h0;
            st_wr_en    = int'(clr_cnt_q) < ST_DEPTH;
            st_wr_addr  = ST_AW'(clr_cnt_q);
            st_wr_data  = 4'h0;
        end
`endif
    end

    // Plain arrays with a registered read port so both map onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
        if (st_wr_en) stat[st_wr_addr] <= st_wr_data;
        if (cyc == PH_X1) begin
            mem_rd_q <= mem[mem_idx];
            st_rd_q  <= stat[st_idx];
        end
    end

    for (genvar gi = 0; gi < NUM_CHIPS; gi++) begin : g_io
        char_t io_q, io_d;

        always_comb begin
            io_d = io_q;
            if (io_we && (chip_idx == gi)) io_d = dbus_in;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) io_q <= 4'h0;
            else        io_q <= io_d;
        end

        assign io_out[4*gi +: 4] = io_q;
    end

endmodule

// File: tb/tb_mcs4_ram_bank.sv
// Directed bench: a 4-chip bank at base 0 and a 1-chip bank at base 2 share one CPU bus.
module tb_mcs4_ram_bank;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sync = 1'b0;
    logic        cm_ram = 1'b0;
    logic [3:0]  dbus_in = 4'h0;
    logic [3:0]  dbus_out, dbus_out2;
    logic        dbus_oe, dbus_oe2;
    logic [15:0] io_out;
    logic [3:0]  io_out2;
    logic        busy, busy2;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] x2_data, x2_data2;
    logic       x2_oe, x2_oe2;
    int         stray;
    logic [3:0] post_rst_val;

    mcs4_ram_bank u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sync     (sync),
        .cm_ram   (cm_ram),
        .dbus_in  (dbus_in),
        .dbus_out (dbus_out),
        .dbus_oe  (dbus_oe),
        .io_out   (io_out),
        .busy     (busy)
    );

    mcs4_ram_bank #(.NUM_CHIPS(1), .CHIP_BASE(2)) u_dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .sync     (sync),
        .cm_ram   (cm_ram),
        .dbus_in  (dbus_in),
        .dbus_out (dbus_out2),
        .dbus_oe  (dbus_oe2),
        .io_out   (io_out2),
        .busy     (busy2)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One instruction cycle, one slot per phase (slot index == phase A1..X3).
    task automatic instr(input logic [3:0] m2_nib, input logic m2_cm, input logic [3:0] x2_nib,
                         input logic x2_cm, input logic [3:0] x3_nib,
                         input int n_slots, input int sync_slot, input int rst_slot);
        x2_data = 4'h0; x2_oe = 1'b0; x2_data2 = 4'h0; x2_oe2 = 1'b0; stray = 0;
        for (int p = 0; p < n_slots; p++) begin
            if (p == 6) begin
                x2_data = dbus_out; x2_oe = dbus_oe;
                x2_data2 = dbus_out2; x2_oe2 = dbus_oe2;
            end else if (dbus_oe || dbus_out != 4'h0 || dbus_oe2 || dbus_out2 != 4'h0) begin
                stray++;
            end
            dbus_in = (p == 4) ? m2_nib : (p == 6) ? x2_nib : (p == 7) ? x3_nib : 4'h0;
            cm_ram  = (p == 4) ? m2_cm : (p == 6) ? x2_cm : 1'b0;
            sync    = (p == sync_slot);
            if (p == rst_slot) rst_n = 1'b0;
            @(posedge clk);
            #1;
            rst_n = 1'b1;
        end
        sync = 1'b0; cm_ram = 1'b0; dbus_in = 4'h0;
    endtask

    task automatic src(input logic [3:0] hi, input logic [3:0] lo, input logic cm);
        instr(4'h0, 1'b0, hi, cm, lo, 8, 7, -1);
    endtask

    task automatic io(input logic [3:0] op, input logic [3:0] data);
        instr(op, 1'b1, data, 1'b0, 4'h0, 8, 7, -1);
    endtask

    task automatic chk_read(input string tag, input logic [3:0] d1, input logic oe1,
                            input logic [3:0] d2, input logic oe2);
        check({tag, "_data"}, 16'(x2_data), 16'(d1));
        check({tag, "_oe"}, 16'(x2_oe), 16'(oe1));
        check({tag, "_data2"}, 16'(x2_data2), 16'(d2));
        check({tag, "_oe2"}, 16'(x2_oe2), 16'(oe2));
        check({tag, "_stray"}, 16'(stray), 16'd0);
    endtask

    task automatic resync();
`ifdef RAM_BANK_CLEAR_EN
        int c1 = 0;
        int c2 = 0;
        for (int i = 0; i < 2000; i++) begin
            if (busy) c1++;
            if (busy2) c2++;
            if (c1 > 0 && c2 > 0 && !busy && !busy2) break;
            @(posedge clk);
            #1;
        end
        check("sweep_len", 16'(c1), 16'd256);
        check("sweep_len2", 16'(c2), 16'd64);
`else
        check("busy_idle", 16'(busy), 16'd0);
`endif
        sync = 1'b1;
        @(posedge clk);
        #1;
        sync = 1'b0;
    endtask

    initial begin
`ifdef RAM_BANK_CLEAR_EN
        post_rst_val = 4'h0;
`else
        post_rst_val = 4'h6;
`endif
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dbus_out", 16'(dbus_out), 16'h0);
        check("rst_dbus_oe", 16'(dbus_oe), 16'h0);
        check("rst_io_out", io_out, 16'h0);
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_io_out2", 16'(io_out2), 16'h0);
        rst_n = 1'b1;
        resync();

        // chip1 reg2 char3: write A then read it back in the next instruction
        src(4'h6, 4'h3, 1'b1);
        io(4'h0, 4'hA);
        check("wrm_nodrive", 16'(x2_oe), 16'h0);
        io(4'h9, 4'h0);
        chk_read("rdm_a", 4'hA, 1'b1, 4'h0, 1'b0);

        // chip3 reg1 status characters
        src(4'hD, 4'h0, 1'b1);
        io(4'h5, 4'h7);
        io(4'h6, 4'h5);
        io(4'hE, 4'h0);
        chk_read("rd2", 4'h5, 1'b1, 4'h0, 1'b0);
        io(4'hD, 4'h0);
        chk_read("rd1", 4'h7, 1'b1, 4'h0, 1'b0);
        io(4'hA, 4'h0);
        chk_read("rdr_ignored", 4'h0, 1'b0, 4'h0, 1'b0);

        // output ports
        src(4'h8, 4'h0, 1'b1);
        io(4'h1, 4'h9);
        check("wmp_chip2", io_out, 16'h0900);
        check("wmp_chip2_b2", 16'(io_out2), 16'h9);
        src(4'h0, 4'h0, 1'b1);
        io(4'h1, 4'h3);
        check("wmp_chip0", io_out, 16'h0903);
        check("wmp_chip0_b2", 16'(io_out2), 16'h9);

        // base-2 bank only answers to chip code 2
        src(4'h8, 4'h5, 1'b1);
        io(4'h0, 4'h6);
        io(4'h9, 4'h0);
        chk_read("chip2_rdm", 4'h6, 1'b1, 4'h6, 1'b1);
        src(4'h0, 4'h5, 1'b1);
        io(4'h0, 4'hC);
        io(4'h9, 4'h0);
        chk_read("chip0_rdm", 4'hC, 1'b1, 4'h0, 1'b0);
        src(4'h8, 4'h5, 1'b1);
        io(4'h9, 4'h0);
        chk_read("chip2_kept", 4'h6, 1'b1, 4'h6, 1'b1);

        // no CM-RAM: SRC, write and read all ignored
        instr(4'h0, 1'b0, 4'h4, 1'b0, 4'h1, 8, 7, -1);
        instr(4'h0, 1'b0, 4'hF, 1'b0, 4'h0, 8, 7, -1);
        instr(4'h9, 1'b0, 4'h0, 1'b0, 4'h0, 8, 7, -1);
        chk_read("nocm_rd", 4'h0, 1'b0, 4'h0, 1'b0);
        io(4'h9, 4'h0);
        chk_read("nocm_kept", 4'h6, 1'b1, 4'h6, 1'b1);

        // SYNC mid-cycle: at M1 before the opcode, and at X1 after a WRM was latched
        instr(4'h0, 1'b1, 4'hF, 1'b0, 4'h0, 4, 3, -1);
        instr(4'h0, 1'b1, 4'hF, 1'b0, 4'h0, 6, 5, -1);
        io(4'h9, 4'h0);
        chk_read("resync_nowr", 4'h6, 1'b1, 4'h6, 1'b1);

        // reset at X1 of a WRM
        instr(4'h0, 1'b1, 4'hF, 1'b0, 4'h0, 6, -1, 5);
        check("midrst_io_out", io_out, 16'h0);
        check("midrst_io_out2", 16'(io_out2), 16'h0);
        check("midrst_oe", 16'(dbus_oe), 16'h0);
        resync();
        src(4'h8, 4'h5, 1'b1);
        io(4'h9, 4'h0);
        chk_read("midrst_loc", post_rst_val, 1'b1, post_rst_val, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mcs4_ram_bank.md
Name: mcs4_ram_bank

Overview:
- Parametrised 4002-class RAM bank. One instance holds NUM_CHIPS RAM chips that all share one CM-RAM line.
- Each chip has REGS registers of CHARS main characters plus STATUS status characters, and a 4-bit output port.
- The block decodes SRC and the I/O-RAM opcodes from the 4-bit MCS-4 data bus using a locally regenerated 8-phase instruction cycle.
- It sits on the CPU data bus beside the i4001 ROMs. The bus-level mux combines dbus_out using dbus_oe.

Parameters:
- NUM_CHIPS, 4, number of chips in the bank (1..4).
- CHIP_BASE, 0, chip-select code of chip 0. Chip k responds to code CHIP_BASE+k, and CHIP_BASE+NUM_CHIPS must be ≤ 4.
- REGS, 4, registers per chip (1..4). Indexed by the low 2 bits of the SRC high nibble.
- CHARS, 16, main characters per register (1..16).
- STATUS, 4, status characters per register (1..4).

Ports:
- clk  in  1  system clock; one clk equals one instruction phase.
- rst_n  in  1  asynchronous active-low reset.
- sync  in  1  CPU SYNC; high during the clk preceding A1.
- cm_ram  in  1  bank select, as driven by the CPU.
- dbus_in  in  4  data bus from the CPU.
- dbus_out  out  4  read data; 0 when not driving.
- dbus_oe  out  1  high only while this bank drives dbus_out.
- io_out  out  4*NUM_CHIPS  output ports; chip k occupies bits [4k+3:4k].
- busy  out  1  clear sweep in progress. Tied 0 unless RAM_BANK_CLEAR_EN is defined.

Behaviour:
- Phase counter: 3 bits, order A1 A2 A3 M1 M2 X1 X2 X3 (0..7).
  - sync forces A1 on the next clk; otherwise the counter increments modulo 8.
  - phase_valid is cleared by reset and set by the first sync. The block ignores the bus while phase_valid is 0.
  - A sync arriving mid-cycle restarts at A1 and discards any latched opcode.
- SRC: at X2, with cm_ram=1, latch the high nibble and set src_pending. At X3, if src_pending, latch the low nibble as the char index.
  - The address {chip[1:0], reg[1:0], char[3:0]} persists until the next SRC to this bank.
  - An SRC without cm_ram leaves the address unchanged.
- Opcode: at M2, latch dbus_in and set op_valid=cm_ram. op_valid applies to the current cycle only and is cleared at A1.
- Selected: op_valid, phase_valid, busy=0, and the chip code lies in [CHIP_BASE, CHIP_BASE+NUM_CHIPS-1].
  - An out-of-range reg or char index (≥ REGS/CHARS) counts as unselected: no write and no drive.
  - A status index ≥ STATUS behaves the same way.
- Reads (registered at X1 and driven for the whole of X2):
  - RDM, SBM and ADM (9, 8, B) return mem[chip][reg][char].
  - RD0..RD3 (C..F) return status[chip][reg][n].
  - dbus_oe=1 and dbus_out=data during X2 only; otherwise dbus_oe=0 and dbus_out=0.
- Writes (captured at the X2 edge):
  - WRM (0) writes mem.
  - WMP (1) writes io_out of the selected chip.
  - WR0..WR3 (4..7) write status[n].
  - WRR, WPM and RDR (2, 3, A) are ignored, with no drive.
- Latency: a read that follows a write to the same location in the next instruction returns the new value.
- Reset values: dbus_out 0, dbus_oe 0, io_out 0, busy 0, address 0, op_valid 0, src_pending 0, phase_valid 0. Memory contents are undefined unless RAM_BANK_CLEAR_EN is defined.
- Reset mid-instruction aborts the instruction; no partial write occurs.

Optional Feature:
- Macro: RAM_BANK_CLEAR_EN.
- Defined: after rst_n deasserts, a sweep FSM (IDLE→CLEAR→IDLE) writes 0 to one main location and one status location per clk across all chips. busy=1 during the sweep and opcodes are ignored. The sweep lasts NUM_CHIPS*REGS*CHARS clks; status clears within the same sweep. Reasserting rst_n during the sweep restarts it.
- Undefined: no FSM, busy tied to 0, no memory reset.

Decomposition:
- Package mcs4 holds char_t, instr_cyc_t, ioram_opa_t (opcodes 0..F as above), and the Ram_regs_per_chip / Ram_chars_per_reg / Ram_status_per_reg defaults.
- Sub-module mcs4_phase_gen (sync → phase, phase_valid) is shared with i4001-class blocks.

Test Plan:
- NUM_CHIPS=4, CHIP_BASE=0: SRC 0x6_3 with cm_ram (chip1, reg2, char3), WRM data 0xA, then RDM → dbus_out=0xA with dbus_oe=1 for exactly the X2 clk; other phases give 0.
- SRC chip3/reg1 then WR2 0x5; RD2 → 0x5; RD1 → the value previously written to status[3][1][1], or 0 with RAM_BANK_CLEAR_EN.
- WMP 0x9 to chip2 → io_out[11:8]=0x9 and the other nibbles stay 0; the next WMP 0x3 to chip0 leaves [11:8]=0x9.
- CHIP_BASE=2, NUM_CHIPS=1: SRC chip0 plus WRM/RDM → no write and dbus_oe stays 0; SRC chip2 works.
- cm_ram=0 during SRC and opcode → address unchanged and no access. A sync injected at M1 → the cycle restarts and no write occurs.
- rst_n pulsed low at X1 of a WRM → io_out=0 and the location is unchanged. With RAM_BANK_CLEAR_EN, busy=1 for 256 clks (4×4×16), then RDM returns 0.
